// File: rtl/beat_gen.sv
// Tempo/beat pulse generator: one-cycle tick every `period` enabled cycles,
// with beat position within a bar and a downbeat flag. Period changes apply on wrap or restart.
module beat_gen #(
  parameter int CNT_WIDTH      = 22,
  parameter int DEFAULT_PERIOD = 3125000,
  parameter int BEATS_PER_BAR  = 4,
  parameter int IDX_WIDTH      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic                 period_wr,
  input  logic                 restart,
  output logic                 tick,
  output logic                 bar,
  output logic [IDX_WIDTH-1:0] beat_idx,
  output logic [CNT_WIDTH-1:0] period
);

  localparam logic [CNT_WIDTH-1:0] DEF_PER  = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BEATS_PER_BAR - 1);

  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_pending;
  logic                 r_pend_valid;
  logic                 r_tick;
  logic                 r_bar;
  logic [IDX_WIDTH-1:0] r_beat_idx;

  logic [CNT_WIDTH-1:0] w_period_m1;
  logic                 w_wrap;
  logic [CNT_WIDTH-1:0] w_wr_val;
  logic [CNT_WIDTH-1:0] w_pend_nxt;
  logic                 w_pv_nxt;
  logic [CNT_WIDTH-1:0] w_per_nxt;
  logic [IDX_WIDTH-1:0] w_idx_nxt;

  // r_period is never 0, so period-1 cannot underflow.
  assign w_period_m1 = r_period - CNT_WIDTH'(1);
  assign w_wrap      = enable && (r_count == w_period_m1);
  assign w_wr_val    = (period_in == '0) ? CNT_WIDTH'(1) : period_in;

  // A write in the same cycle as a wrap/restart is folded in directly.
  assign w_pend_nxt  = period_wr ? w_wr_val : r_pending;
  assign w_pv_nxt    = period_wr | r_pend_valid;
  assign w_per_nxt   = w_pv_nxt ? w_pend_nxt : r_period;
  assign w_idx_nxt   = (r_beat_idx == LAST_IDX) ? '0 : r_beat_idx + IDX_WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count      <= '0;
      r_period     <= DEF_PER;
      r_pending    <= DEF_PER;
      r_pend_valid <= 1'b0;
      r_tick       <= 1'b0;
      r_bar        <= 1'b0;
      r_beat_idx   <= LAST_IDX;
    end else begin
      r_pending <= w_pend_nxt;
      if (restart) begin
        r_count      <= '0;
        r_tick       <= 1'b0;
        r_bar        <= 1'b0;
        r_beat_idx   <= LAST_IDX;
        r_period     <= w_per_nxt;
        r_pend_valid <= 1'b0;
      end else if (w_wrap) begin
        r_count      <= '0;
        r_tick       <= 1'b1;
        r_bar        <= (w_idx_nxt == '0);
        r_beat_idx   <= w_idx_nxt;
        r_period     <= w_per_nxt;
        r_pend_valid <= 1'b0;
      end else begin
        r_tick       <= 1'b0;
        r_bar        <= 1'b0;
        r_pend_valid <= w_pv_nxt;
        if (enable) r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  assign tick     = r_tick;
  assign bar      = r_bar;
  assign beat_idx = r_beat_idx;
  assign period   = r_period;

endmodule

// File: tb/tb_beat_gen.sv
// Directed bench for beat_gen: cycle-by-cycle vector table from reset release,
// then hand-written async-reset sequences.
module tb_beat_gen;

  localparam int CW = 8;
  localparam int IW = 2;
  localparam int OW = 1 + 1 + IW + CW;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [CW-1:0] period_in;
  logic          period_wr;
  logic          restart;
  logic          tick;
  logic          bar;
  logic [IW-1:0] beat_idx;
  logic [CW-1:0] period;

  beat_gen #(
    .CNT_WIDTH(CW), .DEFAULT_PERIOD(4), .BEATS_PER_BAR(4), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .period_in(period_in),
    .period_wr(period_wr), .restart(restart), .tick(tick), .bar(bar),
    .beat_idx(beat_idx), .period(period)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          wr;
    logic [CW-1:0] pin;
    logic          rs;
    logic          t;
    logic          b;
    logic [IW-1:0] idx;
    logic [CW-1:0] per;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] exp_q[$];
  int            total = 0;
  int            bad   = 0;

  function automatic void add(logic en, logic wr, logic [CW-1:0] pin, logic rs,
                              logic t, logic b, logic [IW-1:0] idx, logic [CW-1:0] per);
    vec_t v;
    v.en = en; v.wr = wr; v.pin = pin; v.rs = rs;
    v.t = t; v.b = b; v.idx = idx; v.per = per;
    vecs.push_back(v);
  endfunction

  function automatic void idle(int n, logic [IW-1:0] idx, logic [CW-1:0] per);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, idx, per);
  endfunction

  function automatic void tk(logic b, logic [IW-1:0] idx, logic [CW-1:0] per);
    add(1'b1, 1'b0, '0, 1'b0, 1'b1, b, idx, per);
  endfunction

  function automatic logic [OW-1:0] pack(logic t, logic b, logic [IW-1:0] idx, logic [CW-1:0] per);
    return {t, b, idx, per};
  endfunction

  // scoreboard
  task automatic check(input string name);
    logic [OW-1:0] act;
    logic [OW-1:0] exp;
    act = {tick, bar, beat_idx, period};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %h but no expected value queued", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        bad++;
        $display("FAIL %s: got tick/bar/idx/period=%h expected %h", name, act, exp);
      end
    end
  endtask

  // driver
  task automatic drive(input logic en, input logic wr, input logic [CW-1:0] pin, input logic rs);
    enable = en; period_wr = wr; period_in = pin; restart = rs;
  endtask

  task automatic apply(input vec_t v, input int n);
    drive(v.en, v.wr, v.pin, v.rs);
    exp_q.push_back(pack(v.t, v.b, v.idx, v.per));
    @(posedge clk);
    #1;
    check($sformatf("vec_edge%0d", n));
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);

    // Release, period 4: ticks on 4,8,12,16,20, downbeat on 4 and 20.
    idle(3, 3, 4); tk(1, 0, 4);
    idle(3, 0, 4); tk(0, 1, 4);
    idle(3, 1, 4); tk(0, 2, 4);
    idle(3, 2, 4); tk(0, 3, 4);
    idle(3, 3, 4); tk(1, 0, 4);
    // Enable low for 3 cycles after 2 edges: tick lands on the 7th edge.
    idle(2, 0, 4);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0, 4);
    idle(1, 0, 4); tk(0, 1, 4);
    // Write 6 at edge 2: old period still wraps at 4, then 6 edges to next tick.
    idle(1, 1, 4); add(1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 1, 4);
    idle(1, 1, 4); tk(0, 2, 6);
    idle(5, 2, 6); tk(0, 3, 6);
    // Write 0 stored as 1: continuous tick after the wrap, bar every 4th.
    add(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 3, 6);
    idle(4, 3, 6); tk(1, 0, 1);
    tk(0, 1, 1); tk(0, 2, 1); tk(0, 3, 1); tk(1, 0, 1); tk(0, 1, 1);
    // Write on a wrap edge takes effect at that same edge.
    add(1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 2, 4);
    // Restart with same-cycle write of 5 at edge 3: downbeat 5 edges later.
    idle(2, 2, 4);
    add(1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 3, 5);
    idle(4, 3, 5); tk(1, 0, 5);

    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(pack(1'b0, 1'b0, 2'd3, 8'd4));
    check("reset_state");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // Tick and bar are high here; async reset must clear them without an edge.
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(pack(1'b0, 1'b0, 2'd3, 8'd4));
    check("async_rst_tick_drop");

    // Pending write of 9, then reset mid-interval must discard it.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 8'd9, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    exp_q.push_back(pack(1'b0, 1'b0, 2'd3, 8'd4));
    check("mid_interval_pending");
    reset = 1'b0;
    #1;
    exp_q.push_back(pack(1'b0, 1'b0, 2'd3, 8'd4));
    check("async_rst_pending");
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      exp_q.push_back(pack(e == 4 || e == 8, e == 4,
                           (e < 4) ? 2'd3 : ((e < 8) ? 2'd0 : 2'd1), 8'd4));
      @(posedge clk);
      #1;
      check($sformatf("post_rst_edge%0d", e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beat_gen.md
Name: beat_gen

Overview:
- Parametrised tempo/beat pulse generator for the synth sequencer. Successor to the fixed 32 Hz beat divider.
- Emits a one-cycle `tick` every `period` enabled clock cycles, where `period` is runtime-programmable.
- Tracks the beat position within a bar and flags the downbeat, so note sequencers and the metronome can share one timebase.
- Tempo changes are glitch-free: they take effect only on a tick boundary or on an explicit restart.

Parameters:
- CNT_WIDTH, 22, width of the period counter and of the period values.
- DEFAULT_PERIOD, 3125000, active period after reset (32 Hz at 100 MHz). Must satisfy 1 <= DEFAULT_PERIOD < 2^CNT_WIDTH.
- BEATS_PER_BAR, 4, ticks per bar. Must be >= 1.
- IDX_WIDTH, 2, width of beat_idx. Must satisfy 2^IDX_WIDTH >= BEATS_PER_BAR.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset. reset=0 clears all state immediately; release is synchronous to clk.
- enable  in  1  1 = counter advances; 0 = counter and beat position freeze.
- period_in  in  CNT_WIDTH  requested tick period in clk cycles.
- period_wr  in  1  one-cycle strobe that captures period_in into the pending register.
- restart  in  1  synchronous phase restart.
- tick  out  1  registered pulse, high one cycle per period.
- bar  out  1  registered pulse, high together with tick on the downbeat (beat_idx becomes 0).
- beat_idx  out  IDX_WIDTH  index of the most recent tick within the bar, 0..BEATS_PER_BAR-1.
- period  out  CNT_WIDTH  currently active period.

Behaviour:
- Reset (reset=0, async) sets:
  - count=0, tick=0, bar=0
  - beat_idx=BEATS_PER_BAR-1
  - period=DEFAULT_PERIOD, pending=DEFAULT_PERIOD, pend_valid=0
- Outputs tick and bar are 0 whenever reset=0.
- Counter:
  - With enable=1, count runs 0..period-1.
  - On the edge where count==period-1: count returns to 0, tick=1 and beat_idx advances, all at that edge.
  - Result: the first tick appears after exactly `period` enabled edges following reset release or restart.
- tick and bar are registered and high for exactly one cycle per wrap, except period=1 (see below).
- beat_idx:
  - Increments modulo BEATS_PER_BAR on each tick.
  - bar=1 on the tick where beat_idx becomes 0.
  - Because of the reset value, the first tick after reset or restart is a downbeat (bar=1, beat_idx=0).
- enable=0:
  - count and beat_idx hold; tick=0 and bar=0 on the following edge.
  - period_wr is still captured.
  - Resuming continues from the held count; there is no phase loss.
- period_wr:
  - Captures period_in into pending and sets pend_valid=1.
  - If several writes occur before a wrap, the last one wins.
  - period_in=0 is stored as 1.
- Period update:
  - On a wrap edge with pend_valid=1: period<=pending and pend_valid<=0. The new period governs the interval that starts at that edge.
  - period_wr asserted on the wrap cycle itself: the period_in value of that cycle is used directly.
- period=1: tick is high every enabled cycle. bar pulses every BEATS_PER_BAR ticks.
- restart=1 (takes priority over wrap and enable):
  - count<=0, tick<=0, bar<=0, beat_idx<=BEATS_PER_BAR-1.
  - Any pending period (or period_in, if period_wr is asserted the same cycle) is applied immediately; pend_valid<=0.
- Reset asserted mid-interval discards all state, including any pending period.
- Arithmetic:
  - count compares against period-1 at CNT_WIDTH width with no overflow.
  - count never exceeds period-1, because a shrinking period is applied only at wrap or restart.

Test Plan:
- Reset release, DEFAULT_PERIOD overridden to 4, enable=1 → tick high on edges 4, 8, 12, 16 (one cycle each); beat_idx 0,1,2,3; bar only on edge 4; bar again on edge 20.
- period=4, enable dropped for 3 cycles after edge 2 → next tick on edge 7. No tick while enable=0.
- period=4, period_wr with period_in=6 at edge 2 → tick at edge 4 (old period), then at edge 10. period output changes to 6 at edge 4.
- period_wr with period_in=0 → period becomes 1 at next wrap; tick then high continuously; bar every 4th cycle.
- restart at edge 3 with period_wr/period_in=5 in the same cycle → no tick at edge 4; tick with bar=1, beat_idx=0 at edge 8.
- reset=0 asserted asynchronously mid-interval with pending write → tick/bar drop immediately, without waiting for a clock edge. After release: period=DEFAULT_PERIOD, first tick after DEFAULT_PERIOD edges with bar=1.
